ps2_host_transmitter: RTL
=========================

# ps2_host_transmitter

Host-to-device PS/2 transmitter, the opposite direction of the keyboard receive path. It sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard. It runs the full PS/2 host sequence: clock inhibit, request-to-send, device-clocked shifting of 8 data bits, odd parity and stop, then the device acknowledge. It sits between game/control logic and the open-drain PS/2 pads. While `busy` is high, the receiver ignores the bus.

## Interface
- `INHIBIT_CYCLES`, default 10000: clk cycles that PS2 clock is held low (100 µs at 100 MHz).
- `START_CYCLES`, default 4: clk cycles that clock and data are both held low before clock is released.
- `TIMEOUT_CYCLES`, default 2000000: maximum clk cycles from clock release to bus-idle (20 ms).
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  command byte; sampled at accept.
- `tx_valid`  in  1  request to send.
- `tx_ready`  out  1  high only in IDLE.
- `ps2_clk_in`  in  1  raw PS/2 clock pad value (asynchronous).
- `ps2_data_in`  in  1  raw PS/2 data pad value (asynchronous).
- `ps2_clk_oe`  out  1  1 = drive PS/2 clock low, 0 = release. The top level builds the open-drain pad.
- `ps2_data_oe`  out  1  1 = drive PS/2 data low, 0 = release.
- `busy`  out  1  high in every state except IDLE.
- `tx_done`  out  1  one-cycle pulse: byte sent and acknowledged by the device.
- `tx_error`  out  1  one-cycle pulse: NACK or timeout.

## Operation
- Both pad inputs pass through a 2-FF synchronizer. A falling edge of the synchronized clock (`fall`) is detected with one extra register.
- Accept: `tx_valid && tx_ready` latches `tx_data` and computes `par = ~^tx_data` (odd parity).
- States:
  - IDLE: both oe = 0.
  - INHIBIT: clk_oe = 1, data_oe = 0, for INHIBIT_CYCLES cycles, then START.
  - START: clk_oe = 1, data_oe = 1 (start bit), for START_CYCLES cycles, then SEND. This ordering pulls data low before clock is released.
  - SEND: clk_oe = 0. The timeout counter starts. Bit counter `bitcnt` is 4 bits, reset to 0. On each `fall`:
    - bitcnt 0..7: data_oe = ~tx_data[bitcnt], LSB first.
    - bitcnt 8: data_oe = ~par.
    - bitcnt 9: data_oe = 0 (stop bit, line released).
    - bitcnt 10: sample synchronized data. 0 means ACK, 1 means NACK. Record the result and go to WAIT_IDLE.
    - bitcnt increments on every `fall`.
  - WAIT_IDLE: both oe = 0. Wait until synchronized clock and data are both 1. Then pulse `tx_done` (ACK) or `tx_error` (NACK) and go to IDLE.
- Timeout: the counter runs through SEND and WAIT_IDLE. When it reaches TIMEOUT_CYCLES, release both lines, pulse `tx_error`, and go to IDLE. This takes priority over a coinciding `fall`.
- `tx_valid` is ignored outside IDLE. `tx_data` changes after accept have no effect.
- No retry logic. The requester handles resends (for example on an 0xFE response seen by the receiver).

## Timing
- Reset (async assert, sync deassert by the top level):
  - state = IDLE.
  - ps2_clk_oe = 0, ps2_data_oe = 0, busy = 0, tx_done = 0, tx_error = 0.
  - tx_ready = 1.
  - All counters = 0.
  - Synchronizer flops are set to 1 (idle bus).
- Accept edge: the next cycle has busy = 1, tx_ready = 0, ps2_clk_oe = 1.
- Clock-low time is exactly INHIBIT_CYCLES + START_CYCLES cycles. Data-low before clock release is exactly START_CYCLES cycles.
- Pad falling edge to `ps2_data_oe` update: 3 clk cycles (2 sync + 1 edge register). This is well within the device's clock-low half period (≥ 30 µs).
- ACK sample: taken in the cycle `fall` is seen for bitcnt 10.
- Bus idle seen to `tx_done`/`tx_error`: 1 cycle. IDLE and tx_ready = 1 follow in the same cycle as the pulse.
- Back-to-back: a new accept is possible in the cycle after the done/error pulse.
- Reset mid-frame: lines are released immediately (async). The device times out its own frame.

## Structure
- Shared package `ps2_pkg`:
  - state enum {IDLE, INHIBIT, START, SEND, WAIT_IDLE}.
  - Command constants: CMD_SET_LEDS = 8'hED, CMD_ENABLE = 8'hF4, CMD_RESET = 8'hFF.
  - Response constants: RSP_ACK = 8'hFA, RSP_RESEND = 8'hFE.
  - `odd_parity` function.
- Sub-module `ps2_line_sync`: 2-FF synchronizer plus falling-edge detect for clock and data. It is shared with the receiver.

## Test plan
Bench uses INHIBIT_CYCLES = 20, START_CYCLES = 4, TIMEOUT_CYCLES = 5000, and a device model clocking at a 40-cycle period.
- Send 0xED with device ACK. Required:
  - clk_oe high for 24 cycles; data_oe high in the last 4 of those.
  - Bits sampled on device rising edges: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once after bus idle; tx_ready returns to 1.
- Send 0xF4 with device ACK. Required: parity bit 0 sampled; tx_done pulses.
- Send 0x00 with the device leaving data high at the 11th clock (NACK). Required: parity bit 1 sampled; tx_error pulses and tx_done does not.
- Device never clocks after release. Required: after 5000 cycles in SEND, tx_error pulses, both oe = 0, state is IDLE.
- tx_valid held high through a frame, with tx_data changed mid-frame. Required: exactly one frame is sent with the original byte, and the second accept occurs the cycle after tx_done.
- rst_n pulsed low during bit 4. Required: both oe = 0 immediately, busy = 0, tx_ready = 1. A following 0xFF send completes with tx_done.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and keyboard receiver.
//   ps2_tx_state_t : host transmitter state encoding
//   CMD_*          : common host-to-keyboard command bytes
//   RSP_*          : common keyboard response bytes
//   odd_parity()   : parity bit that makes the 9-bit frame have odd weight
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    // The parity bit is 1 when the data byte has an even number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync
// Two-flop synchronizer for the raw PS/2 clock and data pads, plus a
// falling-edge detector on each synchronized line. Shared by the host
// transmitter and the keyboard receiver.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   clk_in       : raw PS/2 clock pad value (asynchronous)
//   data_in      : raw PS/2 data pad value (asynchronous)
//   clk_sync     : synchronized PS/2 clock
//   data_sync    : synchronized PS/2 data
//   clk_fall     : one-cycle strobe on a falling edge of clk_sync
//   data_fall    : one-cycle strobe on a falling edge of data_sync
// ---------------------------------------------------------------------------
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall,
    output logic data_fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;
    logic       data_prev;

    // Everything resets to 1 so that an idle (pulled-up) bus produces no
    // spurious falling edge when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_ff    <= 2'b11;
            data_ff   <= 2'b11;
            clk_prev  <= 1'b1;
            data_prev <= 1'b1;
        end else begin
            clk_ff    <= {clk_ff[0], clk_in};
            data_ff   <= {data_ff[0], data_in};
            clk_prev  <= clk_ff[1];
            data_prev <= data_ff[1];
        end
    end

    assign clk_sync  = clk_ff[1];
    assign data_sync = data_ff[1];

    // Edge strobes are combinational so the FSM can react in the same cycle
    // the synchronized level changes.
    assign clk_fall  = clk_prev  & ~clk_ff[1];
    assign data_fall = data_prev & ~data_ff[1];

endmodule

// File: rtl/ps2_host_transmitter.sv
// ---------------------------------------------------------------------------
// ps2_host_transmitter
// Sends one command byte from the host to a PS/2 device: clock inhibit,
// request-to-send, device-clocked shifting of 8 data bits + odd parity +
// stop, then the device acknowledge bit.
// Parameters:
//   INHIBIT_CYCLES : clk cycles the PS/2 clock is held low before start
//   START_CYCLES   : clk cycles clock and data are both low before release
//   TIMEOUT_CYCLES : max clk cycles from clock release to bus idle
// Ports:
//   clk, rst_n     : system clock, asynchronous active-low reset
//   tx_data        : command byte, captured on accept
//   tx_valid       : send request
//   tx_ready       : high only while idle; accept = tx_valid && tx_ready
//   ps2_clk_in     : raw PS/2 clock pad value
//   ps2_data_in    : raw PS/2 data pad value
//   ps2_clk_oe     : 1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe    : 1 = pull PS/2 data low, 0 = release
//   busy           : high in every state except IDLE
//   tx_done        : one-cycle pulse, byte acknowledged by the device
//   tx_error       : one-cycle pulse, NACK or timeout
// ---------------------------------------------------------------------------
module ps2_host_transmitter
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int START_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    // One counter is shared by the inhibit, start and timeout phases, so it
    // must be wide enough for the longest of them.
    localparam int MAX_A      = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int MAX_CYCLES = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t    state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       bitcnt, bitcnt_next;
    logic [7:0]       data_q, data_next;
    logic             par_q, par_next;
    logic             data_bit_oe, data_bit_next;
    logic             nack_q, nack_next;
    logic             done_q, done_next;
    logic             error_q, error_next;
    logic             clk_oe_q, clk_oe_next;
    logic             data_oe_q, data_oe_next;

    logic             clk_sync;
    logic             data_sync;
    logic             clk_fall;
    logic             data_fall_unused;

    ps2_line_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall),
        .data_fall (data_fall_unused)
    );

    // State and datapath registers. The pad enables are registered so the
    // open-drain drivers never see decode glitches, and reset releases both
    // lines immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bitcnt      <= '0;
            data_q      <= '0;
            par_q       <= 1'b0;
            data_bit_oe <= 1'b0;
            nack_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            bitcnt      <= bitcnt_next;
            data_q      <= data_next;
            par_q       <= par_next;
            data_bit_oe <= data_bit_next;
            nack_q      <= nack_next;
            done_q      <= done_next;
            error_q     <= error_next;
            clk_oe_q    <= clk_oe_next;
            data_oe_q   <= data_oe_next;
        end
    end

    // Next-state and datapath logic. During SEND the host changes data on
    // each device clock fall so the device sees it stable on the next rise.
    // The timeout check comes first so it wins over a coinciding fall.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        bitcnt_next   = bitcnt;
        data_next     = data_q;
        par_next      = par_q;
        data_bit_next = data_bit_oe;
        nack_next     = nack_q;
        done_next     = 1'b0;
        error_next    = 1'b0;
        clk_oe_next   = 1'b0;
        data_oe_next  = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (tx_valid) begin
                    data_next  = tx_data;
                    par_next   = odd_parity(tx_data);
                    state_next = INHIBIT;
                end
            end

            INHIBIT: begin
                if (cnt == INHIBIT_LAST) begin
                    cnt_next   = '0;
                    state_next = START;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            START: begin
                if (cnt == START_LAST) begin
                    cnt_next      = '0;
                    bitcnt_next   = '0;
                    data_bit_next = 1'b1;
                    state_next    = SEND;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            SEND: begin
                if (cnt == TIMEOUT_LAST) begin
                    cnt_next      = '0;
                    data_bit_next = 1'b0;
                    error_next    = 1'b1;
                    state_next    = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                    if (clk_fall) begin
                        bitcnt_next = bitcnt + 4'd1;
                        if (bitcnt < 4'd8) begin
                            data_bit_next = ~data_q[bitcnt[2:0]];
                        end else if (bitcnt == 4'd8) begin
                            data_bit_next = ~par_q;
                        end else if (bitcnt == 4'd9) begin
                            data_bit_next = 1'b0;
                        end else begin
                            data_bit_next = 1'b0;
                            nack_next     = data_sync;
                            state_next    = WAIT_IDLE;
                        end
                    end
                end
            end

            WAIT_IDLE: begin
                if (cnt == TIMEOUT_LAST) begin
                    cnt_next   = '0;
                    error_next = 1'b1;
                    state_next = IDLE;
                end else if (clk_sync && data_sync) begin
                    cnt_next   = '0;
                    done_next  = ~nack_q;
                    error_next = nack_q;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: begin
                cnt_next      = '0;
                data_bit_next = 1'b0;
                state_next    = IDLE;
            end
        endcase

        clk_oe_next  = (state_next == INHIBIT) || (state_next == START);
        data_oe_next = (state_next == START) || ((state_next == SEND) && data_bit_next);
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;

endmodule
